// File: rtl/axi_ring_writer.sv
// Streams Sin words through a first-word-fall-through FIFO into fixed-length AXI3
// write bursts that walk a circular buffer at ocm_haddr, wrapping every 2^ocm_width bytes.
//
//  state | meaning
//  IDLE  | waiting for a full burst's worth of words in the FIFO; sync flushes here
//  ADDR  | awvalid held with a stable awaddr until awready
//  DATA  | streaming BURST_LEN beats from the FIFO head, wlast on the final beat
//  RESP  | bready high, waiting for bvalid; deferred sync is applied on exit
module axi_ring_writer #(
    parameter int          DW        = 32,
    parameter int          BURST_LEN = 16,
    parameter int          FIFO_AW   = 6,
    parameter logic [31:0] ocm_haddr = 32'hfffc0000,
    parameter int          ocm_width = 16
) (
    input  logic            AXI_clk,
    input  logic            rst,
    input  logic            sync,
    input  logic [DW-1:0]   Sin,
    input  logic            Ien,
    output logic [31:0]     AXI_awaddr,
    output logic            AXI_awvalid,
    input  logic            AXI_awready,
    output logic [3:0]      AXI_awlen,
    output logic [2:0]      AXI_awsize,
    output logic [1:0]      AXI_awburst,
    output logic [5:0]      AXI_awid,
    output logic [DW-1:0]   AXI_wdata,
    output logic [DW/8-1:0] AXI_wstrb,
    output logic            AXI_wlast,
    output logic            AXI_wvalid,
    input  logic            AXI_wready,
    output logic [5:0]      AXI_wid,
    input  logic            AXI_bvalid,
    output logic            AXI_bready,
    input  logic [1:0]      AXI_bresp,
    input  logic [5:0]      AXI_bid,
    output logic [31:0]     wr_cnt,
    output logic [15:0]     ovf_cnt,
    output logic            bresp_err
);

    localparam int                    DEPTH     = 1 << FIFO_AW;
    localparam int                    BURST_B   = BURST_LEN * DW / 8;
    localparam logic [FIFO_AW:0]      CNT_FULL  = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]      CNT_BURST = (FIFO_AW+1)'(BURST_LEN);
    localparam logic [FIFO_AW:0]      CNT_ONE   = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0]    PTR_ONE   = (FIFO_AW)'(1);
    localparam logic [3:0]            LAST_BEAT = 4'(BURST_LEN - 1);
    localparam logic [ocm_width-1:0]  OFF_STEP  = ocm_width'(BURST_B);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                 state;
    logic [DW-1:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]     wr_ptr, rd_ptr;
    logic [FIFO_AW:0]       count;
    logic [ocm_width-1:0]   offset;
    logic [3:0]             beat_left;
    logic                   pending;
    logic                   flush_idle, flush_resp, push, pop;
    logic                   unused_bid;

    assign AXI_awlen   = LAST_BEAT;
    assign AXI_awsize  = 3'($clog2(DW/8));
    assign AXI_awburst = 2'b01;
    assign AXI_awid    = 6'b111111;
    assign AXI_wid     = 6'b111111;
    assign AXI_wstrb   = '1;
    assign AXI_wdata   = mem[rd_ptr];
    assign unused_bid  = ^AXI_bid;

    // An idle flush keeps a same-cycle word; a deferred flush drops it with the rest.
    assign flush_idle = (state == IDLE) && sync;
    assign flush_resp = (state == RESP) && AXI_bvalid && (pending || sync);
    assign push       = Ien && !flush_resp && (flush_idle || (count != CNT_FULL));
    assign pop        = AXI_wvalid && AXI_wready;

    always_ff @(posedge AXI_clk) begin
        if (push)
            mem[wr_ptr] <= Sin;
    end

    always_ff @(posedge AXI_clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_cnt <= '0;
        end else if (flush_idle || flush_resp) begin
            rd_ptr  <= wr_ptr;
            wr_ptr  <= push ? wr_ptr + PTR_ONE : wr_ptr;
            count   <= push ? CNT_ONE : '0;
            ovf_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (!push && pop)
                count <= count - CNT_ONE;
            if (Ien && (count == CNT_FULL) && (ovf_cnt != 16'hffff))
                ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

    always_ff @(posedge AXI_clk) begin
        if (rst) begin
            state       <= IDLE;
            AXI_awaddr  <= ocm_haddr;
            AXI_awvalid <= 1'b0;
            AXI_wvalid  <= 1'b0;
            AXI_wlast   <= 1'b0;
            AXI_bready  <= 1'b0;
            offset      <= '0;
            wr_cnt      <= '0;
            bresp_err   <= 1'b0;
            pending     <= 1'b0;
            beat_left   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sync) begin
                        offset    <= '0;
                        wr_cnt    <= '0;
                        bresp_err <= 1'b0;
                        pending   <= 1'b0;
                    end else if (count >= CNT_BURST) begin
                        state       <= ADDR;
                        AXI_awvalid <= 1'b1;
                        AXI_awaddr  <= ocm_haddr + 32'(offset);
                    end
                end
                ADDR: begin
                    if (sync)
                        pending <= 1'b1;
                    if (AXI_awready) begin
                        state       <= DATA;
                        AXI_awvalid <= 1'b0;
                        AXI_wvalid  <= 1'b1;
                        AXI_wlast   <= (LAST_BEAT == 4'd0);
                        beat_left   <= LAST_BEAT;
                    end
                end
                DATA: begin
                    if (sync)
                        pending <= 1'b1;
                    if (AXI_wready) begin
                        if (beat_left == 4'd0) begin
                            state      <= RESP;
                            AXI_wvalid <= 1'b0;
                            AXI_wlast  <= 1'b0;
                            AXI_bready <= 1'b1;
                        end else begin
                            beat_left <= beat_left - 4'd1;
                            AXI_wlast <= (beat_left == 4'd1);
                        end
                    end
                end
                RESP: begin
                    if (AXI_bvalid) begin
                        state      <= IDLE;
                        AXI_bready <= 1'b0;
                        if (pending || sync) begin
                            pending   <= 1'b0;
                            offset    <= '0;
                            wr_cnt    <= '0;
                            bresp_err <= 1'b0;
                        end else begin
                            wr_cnt <= wr_cnt + 32'd1;
                            offset <= offset + OFF_STEP;
                            if (AXI_bresp != 2'b00)
                                bresp_err <= 1'b1;
                        end
                    end else if (sync) begin
                        pending <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ring_writer.sv
// Scoreboard bench for axi_ring_writer: expected addresses and beats are queued as
// stimulus is issued; a negedge monitor pops and compares on every AXI handshake.
module tb_axi_ring_writer;

    logic        clk = 1'b0;
    logic        rst, sync, Ien;
    logic [31:0] Sin;
    logic [31:0] AXI_awaddr;
    logic        AXI_awvalid, AXI_awready;
    logic [3:0]  AXI_awlen;
    logic [2:0]  AXI_awsize;
    logic [1:0]  AXI_awburst;
    logic [5:0]  AXI_awid;
    logic [31:0] AXI_wdata;
    logic [3:0]  AXI_wstrb;
    logic        AXI_wlast, AXI_wvalid, AXI_wready;
    logic [5:0]  AXI_wid;
    logic        AXI_bvalid, AXI_bready;
    logic [1:0]  AXI_bresp;
    logic [5:0]  AXI_bid;
    logic [31:0] wr_cnt;
    logic [15:0] ovf_cnt;
    logic        bresp_err;

    always #5 clk = ~clk;

    axi_ring_writer #(
        .DW(32), .BURST_LEN(16), .FIFO_AW(6),
        .ocm_haddr(32'hfffc0000), .ocm_width(8)
    ) dut (
        .AXI_clk(clk), .rst(rst), .sync(sync), .Sin(Sin), .Ien(Ien),
        .AXI_awaddr(AXI_awaddr), .AXI_awvalid(AXI_awvalid), .AXI_awready(AXI_awready),
        .AXI_awlen(AXI_awlen), .AXI_awsize(AXI_awsize), .AXI_awburst(AXI_awburst),
        .AXI_awid(AXI_awid), .AXI_wdata(AXI_wdata), .AXI_wstrb(AXI_wstrb),
        .AXI_wlast(AXI_wlast), .AXI_wvalid(AXI_wvalid), .AXI_wready(AXI_wready),
        .AXI_wid(AXI_wid), .AXI_bvalid(AXI_bvalid), .AXI_bready(AXI_bready),
        .AXI_bresp(AXI_bresp), .AXI_bid(AXI_bid), .wr_cnt(wr_cnt),
        .ovf_cnt(ovf_cnt), .bresp_err(bresp_err)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [32:0] exp_w_q[$];
    int          w_idx  = 0;
    int          w_hs   = 0;
    int          b_hs   = 0;
    int          mode   = 0;   // 0: always ready, 1: random back-pressure, 2: awready low
    int          err_at = -1;
    logic        aw_stall = 1'b0, w_stall = 1'b0;
    logic [31:0] aw_prev, w_prev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("aw_w_exclusive", 64'(AXI_awvalid & AXI_wvalid), 64'd0);
            if (aw_stall)
                chk("aw_hold", {31'd0, AXI_awvalid, AXI_awaddr}, {31'd0, 1'b1, aw_prev});
            if (w_stall)
                chk("w_hold", {31'd0, AXI_wvalid, AXI_wdata}, {31'd0, 1'b1, w_prev});
            if (AXI_awvalid && AXI_awready) begin
                if (exp_addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL aw_unexpected actual=%0h expected=none", AXI_awaddr);
                end else
                    chk("awaddr", 64'(AXI_awaddr), 64'(exp_addr_q.pop_front()));
            end
            if (AXI_wvalid && AXI_wready) begin
                w_hs++;
                if (exp_w_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w_unexpected actual=%0h expected=none", AXI_wdata);
                end else
                    chk("wbeat_last_data", 64'({AXI_wlast, AXI_wdata}), 64'(exp_w_q.pop_front()));
            end
            if (AXI_bvalid && AXI_bready)
                b_hs++;
            aw_stall = AXI_awvalid && !AXI_awready;
            aw_prev  = AXI_awaddr;
            w_stall  = AXI_wvalid && !AXI_wready;
            w_prev   = AXI_wdata;
        end else begin
            aw_stall = 1'b0;
            w_stall  = 1'b0;
        end
    end

    initial begin
        AXI_awready = 1'b1; AXI_wready = 1'b1; AXI_bvalid = 1'b1;
        AXI_bresp = 2'b00; AXI_bid = 6'h3f;
        forever begin
            @(posedge clk); #1;
            case (mode)
                1: begin
                    AXI_awready = ($urandom_range(3) != 0);
                    AXI_wready  = ($urandom_range(3) != 0);
                    AXI_bvalid  = ($urandom_range(3) != 0);
                end
                2: begin
                    AXI_awready = 1'b0; AXI_wready = 1'b1; AXI_bvalid = 1'b1;
                end
                default: begin
                    AXI_awready = 1'b1; AXI_wready = 1'b1; AXI_bvalid = 1'b1;
                end
            endcase
            AXI_bresp = (err_at >= 0 && b_hs == err_at) ? 2'b10 : 2'b00;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic expect_word(input logic [31:0] d);
        exp_w_q.push_back({(w_idx % 16 == 15), d});
        w_idx++;
    endtask

    task automatic send(input logic [31:0] d, input bit exp_it, input int gap);
        Sin = d; Ien = 1'b1;
        if (exp_it) expect_word(d);
        tick(1);
        Ien = 1'b0;
        if (gap > 0) tick(gap);
    endtask

    task automatic do_sync(input bit with_word, input logic [31:0] d);
        sync = 1'b1; Ien = with_word; Sin = d;
        if (with_word) expect_word(d);
        tick(1);
        sync = 1'b0; Ien = 1'b0;
    endtask

    task automatic wait_wr(input string name, input int n, input int budget);
        int c = 0;
        while (wr_cnt != 32'(n) && c < budget) begin @(negedge clk); c++; end
        chk(name, 64'(wr_cnt), 64'(n));
        tick(1);
    endtask

    task automatic wait_cnt(input string name, input bit use_b, input int n, input int budget);
        int c = 0;
        while ((use_b ? b_hs : w_hs) < n && c < budget) begin @(negedge clk); c++; end
        chk(name, 64'(use_b ? b_hs : w_hs), 64'(n));
    endtask

    initial begin
        rst = 1'b1; sync = 1'b0; Ien = 1'b0; Sin = '0;
        tick(3);
        chk("rst_valids", {61'd0, AXI_awvalid, AXI_wvalid, AXI_bready}, 64'd0);
        chk("rst_wlast", 64'(AXI_wlast), 64'd0);
        chk("rst_awaddr", 64'(AXI_awaddr), 64'hfffc0000);
        chk("rst_counters", {15'd0, bresp_err, ovf_cnt, wr_cnt}, 64'd0);
        chk("const_aw", {49'd0, AXI_awlen, AXI_awsize, AXI_awburst, AXI_awid}, {49'd0, 4'd15, 3'd2, 2'b01, 6'h3f});
        chk("const_w", {54'd0, AXI_wstrb, AXI_wid}, {54'd0, 4'hf, 6'h3f});
        rst = 1'b0;
        tick(1);

        // four bursts back to back, then a fifth that wraps the ring
        foreach (exp_addr_q[i]) ;
        exp_addr_q.push_back(32'hfffc0000); exp_addr_q.push_back(32'hfffc0040);
        exp_addr_q.push_back(32'hfffc0080); exp_addr_q.push_back(32'hfffc00c0);
        for (int i = 0; i < 64; i++) send(32'ha000_0000 + 32'(i), 1'b1, 0);
        wait_wr("wr_cnt_4", 4, 400);
        exp_addr_q.push_back(32'hfffc0000);
        for (int i = 0; i < 16; i++) send(32'hb000_0000 + 32'(i), 1'b1, 0);
        wait_wr("wr_cnt_wrap", 5, 200);

        // error response on the second burst is sticky until sync
        do_sync(1'b0, '0);
        chk("sync_wr_cnt", 64'(wr_cnt), 64'd0);
        err_at = b_hs + 1;
        exp_addr_q.push_back(32'hfffc0000); exp_addr_q.push_back(32'hfffc0040);
        exp_addr_q.push_back(32'hfffc0080);
        for (int i = 0; i < 48; i++) send(32'hc000_0000 + 32'(i), 1'b1, 0);
        wait_wr("wr_cnt_b1", 1, 200);
        chk("bresp_err_before", 64'(bresp_err), 64'd0);
        wait_wr("wr_cnt_b3", 3, 300);
        chk("bresp_err_set", 64'(bresp_err), 64'd1);
        err_at = -1;
        tick(5);
        chk("bresp_err_sticky", 64'(bresp_err), 64'd1);
        do_sync(1'b0, '0);
        chk("bresp_err_cleared", {31'd0, bresp_err, wr_cnt}, 64'd0);

        // random back-pressure, 320 words
        mode = 1;
        for (int i = 0; i < 20; i++) exp_addr_q.push_back(32'hfffc0000 + 32'((i * 64) % 256));
        for (int i = 0; i < 320; i++) send(32'hd000_0000 + 32'(i * 3), 1'b1, 3);
        wait_wr("wr_cnt_random", 20, 20000);
        mode = 0;
        chk("ovf_random", 64'(ovf_cnt), 64'd0);

        // overflow with awready held low
        do_sync(1'b0, '0);
        mode = 2;
        exp_addr_q.push_back(32'hfffc0000); exp_addr_q.push_back(32'hfffc0040);
        exp_addr_q.push_back(32'hfffc0080); exp_addr_q.push_back(32'hfffc00c0);
        for (int i = 0; i < 100; i++) send(32'he000_0000 + 32'(i), (i < 64), 0);
        tick(5);
        chk("ovf_cnt_36", 64'(ovf_cnt), 64'd36);
        chk("aw_stalled", 64'(AXI_awvalid), 64'd1);
        mode = 0;
        wait_wr("wr_cnt_drain", 4, 600);

        // sync mid-burst: burst finishes, then counters/offset/FIFO reset
        do_sync(1'b0, '0);
        begin
            int wb, bb;
            wb = w_hs; bb = b_hs;
            exp_addr_q.push_back(32'hfffc0000);
            for (int i = 0; i < 20; i++) send(32'h1000_0000 + 32'(i), (i < 16), 0);
            wait_cnt("beat5", 1'b0, wb + 5, 200);
            tick(1);
            do_sync(1'b0, '0);
            wait_cnt("pending_burst_done", 1'b1, bb + 1, 200);
        end
        tick(3);
        chk("pending_wr_cnt", 64'(wr_cnt), 64'd0);
        chk("pending_idle", {62'd0, AXI_awvalid, AXI_bready}, 64'd0);
        exp_addr_q.push_back(32'hfffc0000);
        for (int i = 0; i < 16; i++) send(32'h2000_0000 + 32'(i), 1'b1, 0);
        wait_wr("wr_cnt_after_pending", 1, 200);

        // idle sync with a same-cycle word keeps only that word
        for (int i = 0; i < 4; i++) send(32'hdead_0000 + 32'(i), 1'b0, 0);
        exp_addr_q.push_back(32'hfffc0000);
        do_sync(1'b1, 32'h3000_0000);
        for (int i = 1; i < 16; i++) send(32'h3000_0000 + 32'(i), 1'b1, 0);
        wait_wr("wr_cnt_sync_ien", 1, 200);

        tick(10);
        chk("queues_drained", 64'(exp_addr_q.size() + exp_w_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
